// File: rtl/serial_sub32_pkg.sv
// Shared definitions for the byte-serial subtractor: FSM states, byte width
// and the counter-width helper used to size the byte index.
package serial_sub32_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, never less than 1 so a counter always has at least one bit
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << w) < value) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_sub32_sub8_slice.sv
// sub8_slice: combinational 8-bit subtract with active-high borrow in/out.
// Internally it is a carry-in subtractor (a + ~b + cin); the carry sense is
// inverted at this boundary so callers only ever see borrows.
module sub8_slice
    import serial_sub32_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              bin,
    output logic [BYTE_W-1:0] diff,
    output logic              bout
);

    logic              cin;
    logic [BYTE_W:0]   sum;

    // Borrow-in of 1 means carry-in of 0 for the two's-complement subtractor
    assign cin  = ~bin;
    assign sum  = {1'b0, a} + {1'b0, ~b} + {{BYTE_W{1'b0}}, cin};
    assign diff = sum[BYTE_W-1:0];
    // Carry-out of 1 means no borrow was needed
    assign bout = ~sum[BYTE_W];

endmodule

// File: rtl/serial_sub32.sv
// serial_sub32: byte-serial subtractor computing a - b - bin over NBYTES
// cycles through a single 8-bit slice, with valid/ready handshakes on both
// sides. Optional feature: define SERIAL_SUB_ZERO_FLAG_EN to add the 'zero'
// output (result-is-zero flag accumulated byte by byte).
module serial_sub32
    import serial_sub32_pkg::*;
#(
    parameter int NBYTES = 4
)
(
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    input  logic                     bin,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [BYTE_W*NBYTES-1:0] diff,
    output logic                     bout,
    output logic                     out_valid,
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    output logic                     zero,
`endif
    input  logic                     out_ready
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int CNT_W = clog2(NBYTES);

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [W-1:0]        a_reg;
    logic [W-1:0]        b_reg;
    logic                borrow_reg;
    logic                in_ready_reg;
    logic                out_valid_reg;
    logic [BYTE_W-1:0]   slice_diff;
    logic                slice_bout;
    logic                last_byte;

    // Operands shift right one byte per RUN cycle, so the slice always sees byte 0
    sub8_slice u_slice (
        .a    (a_reg[BYTE_W-1:0]),
        .b    (b_reg[BYTE_W-1:0]),
        .bin  (borrow_reg),
        .diff (slice_diff),
        .bout (slice_bout)
    );

    assign last_byte = (cnt_reg == CNT_W'(NBYTES - 1));

    // Control FSM: accept in IDLE, one byte per cycle in RUN, hold result in DONE.
    // out_valid is a registered output that rises on the edge after DONE is
    // entered, giving the result one settled cycle before it is presented.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            borrow_reg    <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg        <= a;
                        b_reg        <= b;
                        borrow_reg   <= bin;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    a_reg      <= a_reg >> BYTE_W;
                    b_reg      <= b_reg >> BYTE_W;
                    borrow_reg <= slice_bout;
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                    if (last_byte) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid_reg && out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end else begin
                        out_valid_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // One result byte register per byte lane, written when the counter selects it
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_diff_byte
            logic [BYTE_W-1:0] byte_reg;

            // Capture the slice difference for lane gi
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    byte_reg <= '0;
                end else if (state_reg == RUN && cnt_reg == CNT_W'(gi)) begin
                    byte_reg <= slice_diff;
                end
            end

            assign diff[gi*BYTE_W +: BYTE_W] = byte_reg;
        end
    endgenerate

`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic zero_reg;

    // Zero flag starts true at acceptance and is cleared by any non-zero byte
    always_ff @(posedge CLK) begin
        if (RESET) begin
            zero_reg <= 1'b0;
        end else if (state_reg == IDLE && in_valid) begin
            zero_reg <= 1'b1;
        end else if (state_reg == RUN) begin
            zero_reg <= zero_reg & ~|slice_diff;
        end
    end

    assign zero = zero_reg;
`endif

    assign bout      = borrow_reg;
    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_serial_sub32.sv
// Self-checking bench for serial_sub32 (NBYTES=4): directed cases with literal
// expectations plus randomized operations against an arithmetic model.
module tb_serial_sub32;

    logic        CLK;
    logic        RESET;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] diff;
    logic        bout;
    logic        out_valid;
    logic        out_ready;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic        zero;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] d;
        logic        bo;
        logic        z;
        int          acc;
    } exp_t;

    exp_t q[$];
    logic prev_valid = 1'b0;

    serial_sub32 #(.NBYTES(4)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .bout      (bout),
        .out_valid (out_valid),
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        .zero      (zero),
`endif
        .out_ready (out_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic on the whole word
    function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb_v,
                                   input logic tbin, input int acc);
        exp_t e;
        longint unsigned la, lb;
        la    = longint'(ta);
        lb    = longint'(tb_v) + longint'(tbin);
        e.d   = 32'((la + 64'h1_0000_0000 - lb) % 64'h1_0000_0000);
        e.bo  = (la < lb);
        e.z   = (e.d == 32'd0);
        e.acc = acc;
        return e;
    endfunction

    // Compare process: every cycle with a valid result is checked against the model
    always @(negedge CLK) begin
        if (!RESET) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    chk("diff", 64'(diff), 64'(q[0].d));
                    chk("bout", 64'(bout), 64'(q[0].bo));
`ifdef SERIAL_SUB_ZERO_FLAG_EN
                    chk("zero", 64'(zero), 64'(q[0].z));
`endif
                    if (!prev_valid) begin
                        chk("latency", 64'(cyc - q[0].acc), 64'd5);
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                    end
                end
            end
            prev_valid = out_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tbin,
                          input int stall, input bit use_lit, input logic [31:0] lit_d,
                          input logic lit_bo, input logic lit_z);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge CLK); #1; n++;
        end
        chk("in_ready_before_op", 64'(in_ready), 64'd1);
        a = ta; b = tb_v; bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge CLK); #1;
        q.push_back(model(ta, tb_v, tbin, cyc));
        in_valid = 1'b0;
        a = $urandom; b = $urandom; bin = 1'($urandom);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge CLK); #1; n++;
            a = $urandom; b = $urandom; bin = 1'($urandom);
        end
        if (!out_valid) begin
            chk("timeout_out_valid", 64'(out_valid), 64'd1);
            q.delete();
        end else begin
            $display("op a=%08h b=%08h bin=%0d -> diff=%08h bout=%0d", ta, tb_v, tbin, diff, bout);
            if (use_lit) begin
                chk("lit_diff", 64'(diff), 64'(lit_d));
                chk("lit_bout", 64'(bout), 64'(lit_bo));
`ifdef SERIAL_SUB_ZERO_FLAG_EN
                chk("lit_zero", 64'(zero), 64'(lit_z));
`endif
            end
            for (int s = 0; s < stall; s++) begin
                @(posedge CLK); #1;
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                chk("stall_in_ready", 64'(in_ready), 64'd0);
            end
            out_ready = 1'b1;
            @(posedge CLK); #1;
            out_ready = 1'b0;
            chk("idle_out_valid", 64'(out_valid), 64'd0);
            chk("idle_in_ready", 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t pin;
        RESET = 1'b1; a = '0; b = '0; bin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk("reset_diff", 64'(diff), 64'd0);
        chk("reset_bout", 64'(bout), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // Pin the model to hand-computed values
        pin = model(32'h0000_0000, 32'h0000_0001, 1'b0, 0);
        chk("model_wrap", {31'd0, pin.bo, pin.d}, {31'd0, 1'b1, 32'hFFFF_FFFF});
        pin = model(32'h0000_0100, 32'h0000_0001, 1'b0, 0);
        chk("model_xbyte", {31'd0, pin.bo, pin.d}, {31'd0, 1'b0, 32'h0000_00FF});

        // Directed cases with literal results
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(32'h1234_5678, 32'h0234_5678, 1'b0, 0, 1'b1, 32'h1000_0000, 1'b0, 1'b0);
        run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        run_op(32'h0000_0100, 32'h0000_0001, 1'b0, 0, 1'b1, 32'h0000_00FF, 1'b0, 1'b0);
        run_op(32'h0000_0005, 32'h0000_0005, 1'b1, 0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 10, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);

        // Reset on the second RUN cycle discards the operation
        a = 32'h8000_0000; b = 32'h0000_0001; bin = 1'b0; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        chk("midrun_reset_diff", 64'(diff), 64'd0);
        chk("midrun_reset_bout", 64'(bout), 64'd0);
        chk("midrun_reset_in_ready", 64'(in_ready), 64'd1);
        $display("reset during RUN: diff=%08h out_valid=%0d", diff, out_valid);
        repeat (10) @(posedge CLK);
        #1;
        chk("midrun_no_out_valid", 64'(out_valid), 64'd0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0);

        // Reset wins over a simultaneous in_valid
        a = 32'h1; b = 32'h2; bin = 1'b0; in_valid = 1'b1; RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0; in_valid = 1'b0;
        $display("reset with in_valid: in_ready=%0d", in_ready);
        chk("reset_prio_in_ready", 64'(in_ready), 64'd1);
        repeat (8) @(posedge CLK);
        #1;
        chk("reset_prio_no_valid", 64'(out_valid), 64'd0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 4))
                0: rb = ra;
                1: ra = rb + 32'd1;
                2: ra = 32'd0;
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), 1'b0, '0, 1'b0, 1'b0);
        end

        repeat (3) @(posedge CLK);
        #1;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
